ym_ch_accum_buf: RTL and testbench

YM_CH_ACCUM_BUF -- requirements
Module: ym_ch_accum_buf

---
 rtl/ym_ch_accum_buf.sv | 137 +++++++++++++
 tb/tb_ym_ch_accum_buf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ym_ch_accum_buf.sv
// Sums operator slots into per-channel samples and hands each complete frame to a read buffer that drains one channel per beat.
// A completed frame is visible on out_valid the cycle after its last op; out_ready only stalls the read side, and a frame that finds the read buffer still full is dropped.
module ym_ch_accum_buf #(
    parameter int CH_COUNT = 6,
    parameter int OP_COUNT = 4,
    parameter int W        = 9,
    parameter int DAC_CH   = 5
) (
    input  logic                        MCLK,
    input  logic                        reset,
    input  logic                        frame_sync,
    input  logic                        op_valid,
    input  logic signed [W-1:0]         op_value,
    input  logic                        op_out,
    input  logic                        dac_en,
    input  logic signed [W-1:0]         dac_value,
    input  logic [2*CH_COUNT-1:0]       pan,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic signed [W-1:0]         ch_out,
    output logic [1:0]                  ch_pan,
    output logic [$clog2(CH_COUNT)-1:0] ch_idx,
    output logic                        sat,
    output logic                        overrun
);

    localparam int CW = $clog2(CH_COUNT);
    localparam int OW = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1;
    localparam logic [OW-1:0] OP_LAST = OW'(OP_COUNT - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(CH_COUNT - 1);
    localparam logic [CW-1:0] DAC_IDX = CW'(DAC_CH);
    localparam bit DAC_OK = (DAC_CH >= 0) && (DAC_CH < CH_COUNT);
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    logic [OW-1:0]       op_cnt;
    logic [CW-1:0]       ch_cnt;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] wbuf [CH_COUNT];
    logic signed [W-1:0] rbuf [CH_COUNT];
    logic                rd_full;
    logic [CW-1:0]       rd_idx;

    logic [OW-1:0]       cur_op;
    logic [CW-1:0]       cur_ch;
    logic signed [W-1:0] term;
    logic signed [W:0]   ext;
    logic                ovf;
    logic signed [W-1:0] sum;
    logic                sat_evt, ch_done, frame_done;
    logic                rd_accept, rd_last, rd_load;

    always_comb begin
        // frame_sync on the same cycle as an op makes that op slot 0 of channel 0
        cur_op     = frame_sync ? '0 : op_cnt;
        cur_ch     = frame_sync ? '0 : ch_cnt;
        term       = op_out ? op_value : '0;
        ext        = {acc[W-1], acc} + {term[W-1], term};
        ovf        = ext[W] ^ ext[W-1];
        sum        = ext[W-1:0];
        if (cur_op == '0)
            sum = term;
        else if (ovf)
            sum = ext[W] ? S_MIN : S_MAX;
        sat_evt    = op_valid && (cur_op != '0) && ovf;
        ch_done    = op_valid && (cur_op == OP_LAST);
        frame_done = ch_done && (cur_ch == CH_LAST);
        rd_accept  = rd_full && out_ready;
        rd_last    = rd_accept && (rd_idx == CH_LAST);
        rd_load    = frame_done && (!rd_full || rd_last);
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            op_cnt  <= '0;
            ch_cnt  <= '0;
            acc     <= '0;
            rd_full <= 1'b0;
            rd_idx  <= '0;
            sat     <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) begin
                wbuf[i] <= '0;
                rbuf[i] <= '0;
            end
        end else begin
            if (op_valid) begin
                acc <= sum;
                if (cur_op == OP_LAST) begin
                    op_cnt <= '0;
                    ch_cnt <= (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
                end else begin
                    op_cnt <= cur_op + 1'b1;
                    ch_cnt <= cur_ch;
                end
            end else if (frame_sync) begin
                op_cnt <= '0;
                ch_cnt <= '0;
                acc    <= '0;
            end

            if (ch_done)
                wbuf[cur_ch] <= sum;
            if (sat_evt)
                sat <= 1'b1;
            if (frame_done && !rd_load)
                overrun <= 1'b1;

            // the last channel's sum bypasses wbuf so the frame lands in one step
            if (rd_load) begin
                rd_full <= 1'b1;
                rd_idx  <= '0;
                for (int i = 0; i < CH_COUNT; i++)
                    rbuf[i] <= (i == CH_COUNT - 1) ? sum : wbuf[i];
            end else if (rd_accept) begin
                if (rd_idx == CH_LAST) begin
                    rd_full <= 1'b0;
                    rd_idx  <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid = rd_full;
        ch_idx    = rd_idx;
        ch_out    = '0;
        ch_pan    = 2'b00;
        if (rd_full) begin
            ch_out = (DAC_OK && dac_en && rd_idx == DAC_IDX) ? dac_value : rbuf[rd_idx];
            ch_pan = pan[{rd_idx, 1'b0} +: 2];
        end
    end

endmodule

// File: tb/tb_ym_ch_accum_buf.sv
// Directed bench for ym_ch_accum_buf at default parameters: table of per-channel op vectors plus hand sequences for backpressure, overrun and reset.
module tb_ym_ch_accum_buf;
    localparam int W   = 9;
    localparam int CH  = 6;
    localparam int OPS = 4;

    logic MCLK = 1'b0;
    logic reset = 1'b1;
    logic frame_sync = 1'b0, op_valid = 1'b0, op_out = 1'b0, dac_en = 1'b0, out_ready = 1'b1;
    logic signed [W-1:0] op_value = '0, dac_value = '0;
    logic [2*CH-1:0] pan = 12'b10_01_11_00_10_01;
    logic out_valid, sat, overrun;
    logic signed [W-1:0] ch_out;
    logic [1:0] ch_pan;
    logic [2:0] ch_idx;

    ym_ch_accum_buf dut (
        .MCLK(MCLK), .reset(reset), .frame_sync(frame_sync), .op_valid(op_valid),
        .op_value(op_value), .op_out(op_out), .dac_en(dac_en), .dac_value(dac_value),
        .pan(pan), .out_ready(out_ready), .out_valid(out_valid), .ch_out(ch_out),
        .ch_pan(ch_pan), .ch_idx(ch_idx), .sat(sat), .overrun(overrun)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [OPS-1:0][W-1:0] ops;
        logic [OPS-1:0]        mask;
        logic [W-1:0]          exp;
    } chan_vec_t;

    chan_vec_t vec [3*CH];
    logic [1:0] exp_pan [CH] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic setv(input int i, input int a0, input int a1, input int a2, input int a3,
                        input logic [3:0] m, input int e);
        vec[i].ops[0] = W'(a0);
        vec[i].ops[1] = W'(a1);
        vec[i].ops[2] = W'(a2);
        vec[i].ops[3] = W'(a3);
        vec[i].mask   = m;
        vec[i].exp    = W'(e);
    endtask

    task automatic drive_op(input int idx, input int o, input logic sync);
        frame_sync = sync;
        op_valid   = 1'b1;
        op_value   = $signed(vec[idx].ops[o]);
        op_out     = vec[idx].mask[o];
    endtask

    task automatic idle_ops();
        frame_sync = 1'b0;
        op_valid   = 1'b0;
        op_out     = 1'b0;
        op_value   = '0;
    endtask

    task automatic send_frame(input int base, input logic sync_first);
        for (int c = 0; c < CH; c++)
            for (int o = 0; o < OPS; o++) begin
                drive_op(base + c, o, sync_first && c == 0 && o == 0);
                tick();
            end
        idle_ops();
    endtask

    task automatic drain(input int base, input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, " out_valid"}, int'(out_valid), 1);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s ch%0d idx", tag, c), int'(ch_idx), c);
            check($sformatf("%s ch%0d out", tag, c), int'(ch_out), int'($signed(vec[base + c].exp)));
            check($sformatf("%s ch%0d pan", tag, c), int'(ch_pan), int'(exp_pan[c]));
            tick();
        end
        check({tag, " idle valid"}, int'(out_valid), 0);
        check({tag, " idle pan"}, int'(ch_pan), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // frame A: channel c ops all c+1
        for (int c = 0; c < CH; c++)
            setv(c, c + 1, c + 1, c + 1, c + 1, 4'b1111, 4 * (c + 1));
        // frame B: saturation, masking, DAC override on channel 5
        setv(6,   200,  200,  10, 50, 4'b1111,  255);
        setv(7,  -200, -200,   0,  0, 4'b1111, -256);
        setv(8,   100,  100, 100, 100, 4'b0001,  100);
        setv(9,   100,  100, 100, 100, 4'b0001,  100);
        setv(10, -100, -100, -56,  0, 4'b1111, -256);
        setv(11,    1,    2,   3,  4, 4'b1111,   -7);
        // frame C: all ones
        for (int c = 0; c < CH; c++)
            setv(12 + c, 1, 1, 1, 1, 4'b1111, 4);

        #12;
        check("reset out_valid", int'(out_valid), 0);
        check("reset ch_out", int'(ch_out), 0);
        check("reset ch_idx", int'(ch_idx), 0);
        check("reset ch_pan", int'(ch_pan), 0);
        check("reset sat", int'(sat), 0);
        check("reset overrun", int'(overrun), 0);
        @(negedge MCLK);
        reset = 1'b0;
        tick();

        send_frame(0, 1'b1);
        drain(0, "frameA");
        check("frameA sat", int'(sat), 0);

        dac_en = 1'b1;
        dac_value = -9'sd7;
        send_frame(6, 1'b1);
        drain(6, "frameB");
        check("frameB sat", int'(sat), 1);
        check("frameB overrun", int'(overrun), 0);
        dac_en = 1'b0;

        // last accept of a held frame coincides with completion of the next one
        out_ready = 1'b0;
        send_frame(0, 1'b1);
        check("held first valid", int'(out_valid), 1);
        check("held first idx", int'(ch_idx), 0);
        for (int k = 0; k < CH * OPS; k++) begin
            drive_op(12 + k / OPS, k % OPS, k == 0);
            if (k >= 18) begin
                out_ready = 1'b1;
                check($sformatf("overlap beat%0d idx", k - 18), int'(ch_idx), k - 18);
                check($sformatf("overlap beat%0d out", k - 18), int'(ch_out),
                      int'($signed(vec[k - 18].exp)));
            end
            tick();
        end
        idle_ops();
        check("overlap overrun", int'(overrun), 0);
        check("overlap next valid", int'(out_valid), 1);
        check("overlap next idx", int'(ch_idx), 0);
        drain(12, "overlap");

        // second frame arrives while the first is stalled: it is dropped
        out_ready = 1'b0;
        send_frame(0, 1'b1);
        send_frame(6, 1'b1);
        check("stall valid", int'(out_valid), 1);
        check("stall idx", int'(ch_idx), 0);
        check("stall out", int'(ch_out), 4);
        check("stall overrun", int'(overrun), 1);
        drain(0, "stalled");

        // reset in the middle of a held frame and a partial frame
        out_ready = 1'b0;
        send_frame(0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            drive_op(8, 0, k == 0);
            tick();
        end
        idle_ops();
        reset = 1'b1;
        #1;
        check("midreset valid", int'(out_valid), 0);
        check("midreset ch_out", int'(ch_out), 0);
        check("midreset sat", int'(sat), 0);
        check("midreset overrun", int'(overrun), 0);
        @(negedge MCLK);
        reset = 1'b0;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        send_frame(12, 1'b0);
        drain(12, "postreset");
        check("postreset sat", int'(sat), 0);
        check("postreset overrun", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
